// File: rtl/alarm_pkg.sv
// Shared alarm definitions: FSM state encoding, default timing constants
// and counter widths. The countdown stage imports this package as well.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEEP  = 2'd1,
    GAP   = 2'd2,
    PAUSE = 2'd3
  } alarm_state_t;

  localparam int BEEP_CYC_DEF    = 100;
  localparam int GAP_CYC_DEF     = 100;
  localparam int PAUSE_CYC_DEF   = 500;
  localparam int BEEPS_DEF       = 3;
  localparam int TIMEOUT_CYC_DEF = 60000;

  localparam int CNT_W = 16;
  localparam int IDX_W = 3;

  // LED chase step: bit 7 wraps around to bit 0
  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Speaker tone generator: loads high on the first cycle of a beep, toggles
// while the beep continues, and is silent otherwise.
module alarm_tone_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic tone
);

  // Registered tone: load wins over toggle, anything else forces silence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tone <= 1'b0;
    else if (load)
      tone <= 1'b1;
    else if (run)
      tone <= ~tone;
    else
      tone <= 1'b0;
  end

endmodule

// File: rtl/alarm_driver.sv
// Alarm sequencer: bursts of beeps separated by gaps, a pause after each
// burst, self-silencing after TIMEOUT_CYC cycles, immediate stop on STOP.
// Optional LED chase enabled by defining ALARM_DRIVER_LED_EN.
//
// state | meaning
// IDLE  | silent, waiting for START with STOP released
// BEEP  | tone on, toggling every cycle
// GAP   | silence between beeps of one burst
// PAUSE | silence after the last beep of a burst
module alarm_driver
  import alarm_pkg::*;
#(
  parameter int BEEP_CYC    = BEEP_CYC_DEF,
  parameter int GAP_CYC     = GAP_CYC_DEF,
  parameter int PAUSE_CYC   = PAUSE_CYC_DEF,
  parameter int BEEPS       = BEEPS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic       STOP,
  output logic       BZ,
  output logic [7:0] LED,
  output logic       ACTIVE
);

  localparam logic [CNT_W-1:0] BEEP_LAST  = CNT_W'(BEEP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BEEPS - 1);

  alarm_state_t     state;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] tmo;
  logic [IDX_W-1:0] idx;

  logic start_ok, to_idle, beep_end, gap_end, pause_end, beep_load, beep_run;

  // Transition decode shared by the FSM, the tone generator and the LED chase.
  // Timeout and STOP take priority over any phase end on the same cycle.
  always_comb begin
    start_ok  = (state == IDLE) && START && !STOP;
    to_idle   = (state != IDLE) && (STOP || (tmo == TMO_LAST));
    beep_end  = (state == BEEP)  && (phase == BEEP_LAST);
    gap_end   = (state == GAP)   && (phase == GAP_LAST);
    pause_end = (state == PAUSE) && (phase == PAUSE_LAST);
    beep_load = start_ok || (!to_idle && (gap_end || pause_end));
    beep_run  = (state == BEEP) && !to_idle && !beep_end;
  end

  // Main FSM with phase, beep index and timeout counters
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      phase  <= '0;
      idx    <= '0;
      tmo    <= '0;
      ACTIVE <= 1'b0;
    end else if (state == IDLE) begin
      phase <= '0;
      idx   <= '0;
      tmo   <= '0;
      if (start_ok) begin
        state  <= BEEP;
        ACTIVE <= 1'b1;
      end
    end else if (to_idle) begin
      state  <= IDLE;
      ACTIVE <= 1'b0;
      phase  <= '0;
      idx    <= '0;
      tmo    <= '0;
    end else begin
      tmo   <= tmo + 1'b1;
      phase <= phase + 1'b1;
      case (state)
        BEEP: begin
          if (beep_end) begin
            phase <= '0;
            state <= (idx == IDX_LAST) ? PAUSE : GAP;
          end
        end
        GAP: begin
          if (gap_end) begin
            phase <= '0;
            idx   <= idx + 1'b1;
            state <= BEEP;
          end
        end
        PAUSE: begin
          if (pause_end) begin
            phase <= '0;
            idx   <= '0;
            state <= BEEP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  alarm_tone_gen u_tone (
    .clk   (CLOCK),
    .rst_n (RESET),
    .load  (beep_load),
    .run   (beep_run),
    .tone  (BZ)
  );

`ifdef ALARM_DRIVER_LED_EN
  logic [7:0] led_q;

  // LED chase: lit at start, advances on every later beep entry
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      led_q <= 8'h00;
    else if (start_ok)
      led_q <= 8'h01;
    else if (to_idle)
      led_q <= 8'h00;
    else if (beep_load)
      led_q <= rotl8(led_q);
  end

  assign LED = led_q;
`else
  assign LED = 8'h00;
`endif

endmodule

// File: tb/tb_alarm_driver.sv
// Bench for alarm_driver: randomized START/STOP/RESET stimulus, expected
// outputs from a time-since-start reference model, scoreboard queue.
module tb_alarm_driver;

  localparam int BEEP_C  = 4;
  localparam int GAP_C   = 2;
  localparam int PAUSE_C = 6;
  localparam int NBEEPS  = 3;
  localparam int TMO_C   = 100;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic       STOP  = 1'b0;
  logic       BZ;
  logic [7:0] LED;
  logic       ACTIVE;

  alarm_driver #(
    .BEEP_CYC    (BEEP_C),
    .GAP_CYC     (GAP_C),
    .PAUSE_CYC   (PAUSE_C),
    .BEEPS       (NBEEPS),
    .TIMEOUT_CYC (TMO_C)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .START  (START),
    .STOP   (STOP),
    .BZ     (BZ),
    .LED    (LED),
    .ACTIVE (ACTIVE)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic       bz;
    logic [7:0] led;
    logic       act;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  bit m_active = 1'b0;
  int m_t      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Outputs as a pure function of cycles elapsed since the start edge
  function automatic exp_t model_out(input bit act, input int t);
    exp_t e;
    int   period, pos, last, bs, n;
    e = '0;
    if (!act) return e;
    period = NBEEPS * BEEP_C + (NBEEPS - 1) * GAP_C + PAUSE_C;
    pos    = t % period;
    last   = 0;
    for (int i = 0; i < NBEEPS; i++)
      if (pos >= i * (BEEP_C + GAP_C)) last = i;
    bs    = last * (BEEP_C + GAP_C);
    e.act = 1'b1;
    e.bz  = ((pos - bs) < BEEP_C) && (((pos - bs) % 2) == 0);
    n     = (t / period) * NBEEPS + last;
`ifdef ALARM_DRIVER_LED_EN
    e.led = 8'(1 << (n % 8));
`else
    e.led = 8'h00;
    n     = n + 0;
`endif
    return e;
  endfunction

  task automatic model_edge(input bit s, input bit p);
    if (m_active) begin
      if (p) m_active = 1'b0;
      else if (m_t + 1 >= TMO_C) m_active = 1'b0;
      else m_t++;
    end else if (s && !p) begin
      m_active = 1'b1;
      m_t      = 0;
    end
  endtask

  // Drive inputs for the next edge and queue the outputs expected after it
  task automatic step(input bit s, input bit p);
    @(posedge CLOCK);
    #2;
    START = s;
    STOP  = p;
    model_edge(s, p);
    q.push_back(model_out(m_active, m_t));
  endtask

  // Reset between edges: outputs must drop before the next edge
  task automatic reset_mid();
    @(posedge CLOCK);
    #2;
    RESET    = 1'b0;
    START    = 1'b0;
    STOP     = 1'b0;
    m_active = 1'b0;
    #1;
    chk("rst_bz", 32'(BZ), 32'd0);
    chk("rst_led", 32'(LED), 32'd0);
    chk("rst_active", 32'(ACTIVE), 32'd0);
    q.push_back('0);
    @(posedge CLOCK);
    #2;
    RESET = 1'b1;
    q.push_back('0);
  endtask

  // Monitor: compare DUT outputs just after each edge against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge CLOCK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bz", 32'(BZ), 32'(e.bz));
        chk("led", 32'(LED), 32'(e.led));
        chk("active", 32'(ACTIVE), 32'(e.act));
      end
    end
  end

  initial begin
    bit s, p;
    #3;
    chk("por_bz", 32'(BZ), 32'd0);
    chk("por_led", 32'(LED), 32'd0);
    chk("por_active", 32'(ACTIVE), 32'd0);
    repeat (2) @(posedge CLOCK);
    #2;
    RESET = 1'b1;

    // full run to timeout, with a START pulse mid-gap that must be ignored
    step(1, 0);
    for (int i = 0; i < 115; i++) step(i == 4, 0);

    // START and STOP together in IDLE, then STOP held across a START
    step(1, 1);
    step(0, 1);
    step(1, 1);
    step(0, 0);

    // STOP on the second cycle of a beep, then a fresh start
    step(1, 0);
    step(0, 0);
    step(0, 1);
    step(0, 0);
    step(1, 0);
    for (int i = 0; i < 30; i++) step(0, 0);

    // reset asserted mid-beep, then a fresh start is required
    step(0, 1);
    step(1, 0);
    reset_mid();
    for (int i = 0; i < 5; i++) step(0, 0);
    step(1, 0);
    for (int i = 0; i < 25; i++) step(0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        reset_mid();
      end else begin
        s = ($urandom_range(0, 99) < 4);
        p = ($urandom_range(0, 199) < 2);
        step(s, p);
      end
    end

    repeat (3) @(posedge CLOCK);
    #3;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
